// File: rtl/pad_mux_pkg.sv
// Shared types and constants for the pad multiplexer.
// Latency: none (types and constants only).
// Backpressure: none.
`timescale 1ns/1ps
package pad_mux_pkg;

    // Per-pad lane state: ACTIVE drives the selected source, GUARD tristates.
    typedef enum logic {
        ACTIVE = 1'b0,
        GUARD  = 1'b1
    } lane_state_e;

    // Default source numbering on the select bus.
    localparam int SRC_PERIO  = 0;
    localparam int SRC_APBIO  = 1;
    localparam int SRC_FPGAIO = 2;
    localparam int SRC_SPARE  = 3;

    // Width of a down-counter that must hold guard_cyc-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int guard_cyc);
        return (guard_cyc > 1) ? $clog2(guard_cyc) : 1;
    endfunction

endpackage

// File: rtl/pad_mux_lane.sv
// One pad: break-before-make select FSM, input synchroniser, source routing.
// Latency: outputs combinational from cur_sel; pad input SYNC_STAGES cycles; select change GUARD_CYC+1 cycles.
// Backpressure: none; a new request during the guard restarts the guard.
//
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   pad_mux_i      requested select for this pad
//   src_out_i      output data of every source for this pad (bit s = source s)
//   src_oe_i       output enable of every source for this pad
//   src_in_o       pad input returned to every source (idle level when not selected)
//   io_out_o       pad output data
//   io_oe_o        pad output enable
//   io_in_i        raw pad input (asynchronous)
//   busy_o         pad is in its tristate guard window
`timescale 1ns/1ps
module pad_mux_lane
    import pad_mux_pkg::*;
#(
    parameter int               N_SRC       = 4,
    parameter int               SEL_W       = 2,
    parameter int               GUARD_CYC   = 2,
    parameter int               SYNC_STAGES = 2,
    parameter logic [N_SRC-1:0] IDLE_IN     = 4'b0001,
    parameter int               RST_SEL     = SRC_PERIO
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [SEL_W-1:0]  pad_mux_i,
    input  logic [N_SRC-1:0]  src_out_i,
    input  logic [N_SRC-1:0]  src_oe_i,
    output logic [N_SRC-1:0]  src_in_o,
    output logic              io_out_o,
    output logic              io_oe_o,
    input  logic              io_in_i,
    output logic              busy_o
);

    localparam int               CNT_W    = cnt_width(GUARD_CYC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GUARD_CYC - 1);
    localparam logic [SEL_W-1:0] SEL_RST  = SEL_W'(RST_SEL);

    lane_state_e            state_q,   state_d;
    logic [SEL_W-1:0]       cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0]       target_q,  target_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   drive;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ACTIVE;
            cur_sel_q <= SEL_RST;
            target_q  <= SEL_RST;
            cnt_q     <= '0;
            sync_q    <= '0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            // Shift towards the MSB; the cast drops the oldest sample.
            sync_q    <= SYNC_STAGES'({sync_q, io_in_i});
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        case (state_q)
            ACTIVE: begin
                if (pad_mux_i != cur_sel_q) begin
                    state_d  = GUARD;
                    target_d = pad_mux_i;
                    cnt_d    = CNT_LOAD;
                end
            end
            GUARD: begin
                if (pad_mux_i != target_q) begin
                    // Request moved again: restart the full guard for the new target.
                    target_d = pad_mux_i;
                    cnt_d    = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    cur_sel_d = target_q;
                    state_d   = ACTIVE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ACTIVE;
            end
        endcase
    end

    // An out-of-range select leaves the pad tristated and every source idle.
    assign drive  = (state_q == ACTIVE) && (int'(cur_sel_q) < N_SRC);
    assign busy_o = (state_q == GUARD);

    always_comb begin
        io_out_o = 1'b0;
        io_oe_o  = 1'b0;
        src_in_o = IDLE_IN;
        if (drive) begin
            io_out_o            = src_out_i[cur_sel_q];
            io_oe_o             = src_oe_i[cur_sel_q];
            src_in_o[cur_sel_q] = sync_q[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/pad_mux_ctrl.sv
// Pad multiplexer: N_IO independent lanes routing N_SRC sources to pads with break-before-make.
// Latency: pad outputs combinational; pad inputs SYNC_STAGES cycles; select change GUARD_CYC+1 cycles.
// Backpressure: none; busy_o/any_busy_o flag pads inside their guard window.
//
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   pad_mux_i      per-pad requested source select
//   src_out_i      [source][pad] output data from the sources
//   src_oe_i       [source][pad] output enables from the sources
//   src_in_o       [source][pad] synchronised pad inputs (idle level when not selected)
//   io_out_o       per-pad output data
//   io_oe_o        per-pad output enable
//   io_in_i        per-pad raw input
//   busy_o         per-pad guard flag
//   any_busy_o     OR of busy_o
`timescale 1ns/1ps
module pad_mux_ctrl
    import pad_mux_pkg::*;
#(
    parameter int               N_IO        = 48,
    parameter int               N_SRC       = 4,
    parameter int               SEL_W       = $clog2(N_SRC),
    parameter int               GUARD_CYC   = 2,
    parameter int               SYNC_STAGES = 2,
    parameter logic [N_SRC-1:0] IDLE_IN     = 4'b0001,
    parameter int               RST_SEL     = SRC_PERIO
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_IO-1:0][SEL_W-1:0]  pad_mux_i,
    input  logic [N_SRC-1:0][N_IO-1:0]  src_out_i,
    input  logic [N_SRC-1:0][N_IO-1:0]  src_oe_i,
    output logic [N_SRC-1:0][N_IO-1:0]  src_in_o,
    output logic [N_IO-1:0]             io_out_o,
    output logic [N_IO-1:0]             io_oe_o,
    input  logic [N_IO-1:0]             io_in_i,
    output logic [N_IO-1:0]             busy_o,
    output logic                        any_busy_o
);

    // Source-major buses transposed to pad-major so each lane sees one column.
    logic [N_IO-1:0][N_SRC-1:0] lane_out;
    logic [N_IO-1:0][N_SRC-1:0] lane_oe;
    logic [N_IO-1:0][N_SRC-1:0] lane_in;

    always_comb begin
        for (int k = 0; k < N_IO; k++) begin
            for (int s = 0; s < N_SRC; s++) begin
                lane_out[k][s] = src_out_i[s][k];
                lane_oe[k][s]  = src_oe_i[s][k];
            end
        end
    end

    always_comb begin
        for (int s = 0; s < N_SRC; s++) begin
            for (int k = 0; k < N_IO; k++) begin
                src_in_o[s][k] = lane_in[k][s];
            end
        end
    end

    for (genvar k = 0; k < N_IO; k++) begin : g_lane
        pad_mux_lane #(
            .N_SRC       (N_SRC),
            .SEL_W       (SEL_W),
            .GUARD_CYC   (GUARD_CYC),
            .SYNC_STAGES (SYNC_STAGES),
            .IDLE_IN     (IDLE_IN),
            .RST_SEL     (RST_SEL)
        ) u_lane (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .pad_mux_i (pad_mux_i[k]),
            .src_out_i (lane_out[k]),
            .src_oe_i  (lane_oe[k]),
            .src_in_o  (lane_in[k]),
            .io_out_o  (io_out_o[k]),
            .io_oe_o   (io_oe_o[k]),
            .io_in_i   (io_in_i[k]),
            .busy_o    (busy_o[k])
        );
    end

    assign any_busy_o = |busy_o;

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// Self-checking bench for pad_mux_ctrl: directed vector table on pad 0,
// hand-written reset/multi-pad sequences, then random stimulus against a reference model.
`timescale 1ns/1ps
module tb_pad_mux_ctrl;
    import pad_mux_pkg::*;

    localparam int               N_IO        = 48;
    localparam int               N_SRC       = 4;
    localparam int               SEL_W       = 2;
    localparam int               GUARD_CYC   = 2;
    localparam int               SYNC_STAGES = 2;
    localparam logic [N_SRC-1:0] IDLE_IN     = 4'b0001;
    localparam int               RST_SEL     = 0;

    logic                        clk = 1'b0;
    logic                        rst_ni;
    logic [N_IO-1:0][SEL_W-1:0]  pad_mux;
    logic [N_SRC-1:0][N_IO-1:0]  src_out;
    logic [N_SRC-1:0][N_IO-1:0]  src_oe;
    logic [N_SRC-1:0][N_IO-1:0]  src_in;
    logic [N_IO-1:0]             io_out;
    logic [N_IO-1:0]             io_oe;
    logic [N_IO-1:0]             io_in;
    logic [N_IO-1:0]             busy;
    logic                        any_busy;

    always #5 clk = ~clk;

    pad_mux_ctrl #(
        .N_IO(N_IO), .N_SRC(N_SRC), .SEL_W(SEL_W), .GUARD_CYC(GUARD_CYC),
        .SYNC_STAGES(SYNC_STAGES), .IDLE_IN(IDLE_IN), .RST_SEL(RST_SEL)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .pad_mux_i(pad_mux),
        .src_out_i(src_out), .src_oe_i(src_oe), .src_in_o(src_in),
        .io_out_o(io_out), .io_oe_o(io_oe), .io_in_i(io_in),
        .busy_o(busy), .any_busy_o(any_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    function automatic logic [N_SRC-1:0] src_in_col(input int k);
        logic [N_SRC-1:0] r;
        for (int s = 0; s < N_SRC; s++) r[s] = src_in[s][k];
        return r;
    endfunction

    // ---------------- directed vectors on pad 0 ----------------
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [N_SRC-1:0] so;
        logic [N_SRC-1:0] soe;
        logic             io;
        logic             e_out;
        logic             e_oe;
        logic             e_busy;
        logic [N_SRC-1:0] e_sin;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [SEL_W-1:0] sel, input logic [3:0] so, input logic [3:0] soe,
                       input logic io, input logic eo, input logic eoe, input logic eb,
                       input logic [3:0] esin);
        vq.push_back('{sel, so, soe, io, eo, eoe, eb, esin});
    endtask

    // ---------------- reference model ----------------
    // A pad leaves the guard once its request has been seen unchanged for
    // GUARD_CYC+1 consecutive cycles (the cycle that started the change included).
    int               m_cur    [N_IO];
    bit               m_guard  [N_IO];
    int               m_tgt    [N_IO];
    int               m_stable [N_IO];
    logic [N_IO-1:0]  m_hist[$];   // m_hist[0] = pad inputs from SYNC_STAGES cycles ago

    task automatic model_reset();
        for (int k = 0; k < N_IO; k++) begin
            m_cur[k] = RST_SEL; m_guard[k] = 1'b0; m_tgt[k] = RST_SEL; m_stable[k] = 0;
        end
        m_hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back('0);
    endtask

    task automatic model_check(input int cyc);
        logic [N_IO-1:0]            e_out, e_oe, e_busy;
        logic [N_SRC-1:0][N_IO-1:0] e_sin;
        bit                         act;
        for (int k = 0; k < N_IO; k++) begin
            act       = !m_guard[k] && (m_cur[k] < N_SRC);
            e_busy[k] = m_guard[k];
            e_out[k]  = act ? src_out[m_cur[k]][k] : 1'b0;
            e_oe[k]   = act ? src_oe[m_cur[k]][k]  : 1'b0;
            for (int s = 0; s < N_SRC; s++)
                e_sin[s][k] = (act && s == m_cur[k]) ? m_hist[0][k] : IDLE_IN[s];
        end
        chk($sformatf("rnd%0d.io_out", cyc),   256'(io_out),   256'(e_out));
        chk($sformatf("rnd%0d.io_oe", cyc),    256'(io_oe),    256'(e_oe));
        chk($sformatf("rnd%0d.busy", cyc),     256'(busy),     256'(e_busy));
        chk($sformatf("rnd%0d.any_busy", cyc), 256'(any_busy), 256'(|e_busy));
        chk($sformatf("rnd%0d.src_in", cyc),   256'(src_in),   256'(e_sin));
    endtask

    task automatic model_step();
        int req;
        for (int k = 0; k < N_IO; k++) begin
            req = int'(pad_mux[k]);
            if (!m_guard[k]) begin
                if (req != m_cur[k]) begin
                    m_guard[k] = 1'b1; m_tgt[k] = req; m_stable[k] = 1;
                end
            end else if (req != m_tgt[k]) begin
                m_tgt[k] = req; m_stable[k] = 1;
            end else begin
                m_stable[k]++;
                if (m_stable[k] > GUARD_CYC) begin
                    m_cur[k] = m_tgt[k]; m_guard[k] = 1'b0;
                end
            end
        end
        m_hist.push_back(io_in);
        void'(m_hist.pop_front());
    endtask

    task automatic run_random(input int ncyc, input int base);
        for (int c = 0; c < ncyc; c++) begin
            for (int k = 0; k < N_IO; k++)
                if ($urandom_range(0, 5) == 0) pad_mux[k] = SEL_W'($urandom_range(0, N_SRC - 1));
            for (int s = 0; s < N_SRC; s++) begin
                src_out[s] = N_IO'({$urandom(), $urandom()});
                src_oe[s]  = N_IO'({$urandom(), $urandom()});
            end
            io_in = N_IO'({$urandom(), $urandom()});
            @(negedge clk);
            model_check(base + c);
            model_step();
            tick();
        end
    endtask

    // Hard stop in case something stalls the clocked flow.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni  = 1'b0;
        pad_mux = '0;
        src_out = '0;
        src_oe  = '0;
        io_in   = '0;

        // ---- reset state: all pads ACTIVE on source 0, synchronisers cleared ----
        src_oe[0]  = '1;
        src_out[0] = 48'hA5A5_5A5A_F00F;
        #3;
        chk("rst.busy",     256'(busy),     256'(0));
        chk("rst.any_busy", 256'(any_busy), 256'(0));
        chk("rst.io_oe",    256'(io_oe),    256'({N_IO{1'b1}}));
        chk("rst.io_out",   256'(io_out),   256'(48'hA5A5_5A5A_F00F));
        chk("rst.src_in",   256'(src_in),   256'(0));
        do_reset();
        src_oe  = '0;
        src_out = '0;
        repeat (3) tick();

        // ---- directed table (pad 0), one vector per cycle ----
        //   sel  so       soe      io    out   oe    busy  src_in[3:0]
        add(0, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
        add(0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
        add(0, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
        add(0, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001);
        add(0, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        add(1, 4'b0010, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001); // 0->1 requested
        add(1, 4'b0010, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001); // guard
        add(1, 4'b0010, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001); // guard
        add(1, 4'b0010, 4'b0011, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0011); // source 1 live
        add(1, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001);
        add(2, 4'b0100, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001); // 1->2 requested
        add(2, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
        add(3, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001); // 2->3 reloads guard
        add(3, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001);
        add(3, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
        add(3, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001); // source 3 live
        add(3, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001);
        add(0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001); // 3->0 requested
        add(0, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
        add(0, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
        add(0, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);

        foreach (vq[i]) begin
            pad_mux[0] = vq[i].sel;
            for (int s = 0; s < N_SRC; s++) begin
                src_out[s][0] = vq[i].so[s];
                src_oe[s][0]  = vq[i].soe[s];
            end
            io_in[0] = vq[i].io;
            @(negedge clk);
            chk($sformatf("vec%0d.io_out", i),   256'(io_out[0]),     256'(vq[i].e_out));
            chk($sformatf("vec%0d.io_oe", i),    256'(io_oe[0]),      256'(vq[i].e_oe));
            chk($sformatf("vec%0d.busy", i),     256'(busy[0]),       256'(vq[i].e_busy));
            chk($sformatf("vec%0d.any_busy", i), 256'(any_busy),      256'(vq[i].e_busy));
            chk($sformatf("vec%0d.src_in", i),   256'(src_in_col(0)), 256'(vq[i].e_sin));
            tick();
        end

        // ---- reset in the middle of a guard, released with a pending request ----
        src_out[0][0] = 1'b0; src_oe[0][0] = 1'b0;
        src_out[1][0] = 1'b1; src_oe[1][0] = 1'b1;
        pad_mux[0] = 2'd1;
        @(negedge clk);
        chk("rg.pre.busy", 256'(busy[0]), 256'(0));
        tick();
        @(negedge clk);
        chk("rg.guard.busy", 256'(busy[0]), 256'(1));
        chk("rg.guard.oe",   256'(io_oe[0]), 256'(0));
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rg.rst.busy",     256'(busy[0]),       256'(0));
        chk("rg.rst.any_busy", 256'(any_busy),      256'(0));
        chk("rg.rst.oe",       256'(io_oe[0]),      256'(0));
        chk("rg.rst.out",      256'(io_out[0]),     256'(0));
        chk("rg.rst.src_in",   256'(src_in_col(0)), 256'(4'b0000));
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rg.r0.busy", 256'(busy[0]), 256'(0));
        tick();
        @(negedge clk);
        chk("rg.r1.busy", 256'(busy[0]),  256'(1));
        chk("rg.r1.oe",   256'(io_oe[0]), 256'(0));
        tick();
        @(negedge clk);
        chk("rg.r2.busy", 256'(busy[0]),  256'(1));
        chk("rg.r2.oe",   256'(io_oe[0]), 256'(0));
        tick();
        @(negedge clk);
        chk("rg.r3.busy", 256'(busy[0]),   256'(0));
        chk("rg.r3.out",  256'(io_out[0]), 256'(1));
        chk("rg.r3.oe",   256'(io_oe[0]),  256'(1));
        tick();

        // ---- pads 0 and 5 change together; pad 1 must carry on undisturbed ----
        src_out = '0; src_oe = '0;
        src_out[2][0] = 1'b1; src_oe[2][0] = 1'b1;
        src_out[3][5] = 1'b1; src_oe[3][5] = 1'b1;
        src_out[0][1] = 1'b1; src_oe[0][1] = 1'b1;
        pad_mux[0] = 2'd2;
        pad_mux[5] = 2'd3;
        @(negedge clk);
        chk("mp.t0.busy", 256'(busy), 256'(0));
        tick();
        for (int i = 1; i <= GUARD_CYC; i++) begin
            @(negedge clk);
            chk($sformatf("mp.t%0d.busy", i),     256'(busy),      256'(48'h21));
            chk($sformatf("mp.t%0d.any_busy", i), 256'(any_busy),  256'(1));
            chk($sformatf("mp.t%0d.oe0_5", i),    256'({io_oe[5], io_oe[0]}), 256'(0));
            chk($sformatf("mp.t%0d.pad1", i),     256'({io_oe[1], io_out[1]}), 256'(2'b11));
            tick();
        end
        @(negedge clk);
        chk("mp.t3.busy",     256'(busy),     256'(0));
        chk("mp.t3.any_busy", 256'(any_busy), 256'(0));
        chk("mp.t3.pad0",     256'({io_oe[0], io_out[0]}), 256'(2'b11));
        chk("mp.t3.pad5",     256'({io_oe[5], io_out[5]}), 256'(2'b11));
        tick();

        // ---- random stimulus against the reference model, with a reset midway ----
        do_reset();
        model_reset();
        run_random(400, 0);
        do_reset();
        model_reset();
        run_random(400, 400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
